// File: rtl/rom_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rom_fetch_pkg
//
// Definitions shared by the instruction fetch unit and the processor decoder.
// Both sides take instruction length from is_two_byte(), so they always agree
// on which opcodes carry an operand byte.
//
// Contents:
//   state_t           fetch FSM state encoding
//   TWO_BYTE_NIBBLES  bit n set when an opcode with low nibble n is two bytes
//   is_two_byte()     length decode of an opcode byte
// -----------------------------------------------------------------------------
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        S_OP_ADDR  = 2'd0,  // address of the opcode is being presented to the ROM
        S_OP_DATA  = 2'd1,  // ROM data shows the opcode byte
        S_ARG_DATA = 2'd2,  // ROM data shows the operand byte
        S_OUT      = 2'd3   // instruction offered to execute, waiting for ready
    } state_t;

    // Low nibbles 0x0, 0x1, 0x2, 0x3, 0x6, 0x7 and 0x9 mark two-byte opcodes.
    localparam logic [15:0] TWO_BYTE_NIBBLES = 16'h02CF;

    function automatic logic is_two_byte(input logic [7:0] opcode);
        return TWO_BYTE_NIBBLES[opcode[3:0]];
    endfunction

endpackage

// File: rtl/rom_fetch_unit.sv
// -----------------------------------------------------------------------------
// rom_fetch_unit
//
// Instruction fetch front end. Drives the synchronous instruction ROM (one
// cycle read latency), assembles one- or two-byte instructions and offers
// them to the execute stage with a valid/ready handshake. Execute can redirect
// the fetch stream to any address at any time.
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous, active-high reset
//   rom_addr        registered ROM address
//   rom_data        ROM read data for the address seen at the previous edge
//   instr_valid     instruction fields below are valid
//   instr_ready     execute stage accepts the instruction
//   instr_opcode    opcode byte
//   instr_operand   operand byte, zero for one-byte instructions
//   instr_two_byte  instruction carries an operand
//   instr_pc        address of the opcode byte
//   redirect_en     one-cycle request to continue fetching at redirect_addr
//   redirect_addr   redirect target
// -----------------------------------------------------------------------------
module rom_fetch_unit
    import rom_fetch_pkg::*;
#(
    parameter int                      ADDR_WIDTH   = 8,
    parameter int                      DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_operand,
    output logic                  instr_two_byte,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_addr
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;       // address of the instruction being assembled/offered
    logic [ADDR_WIDTH-1:0]   pc_next;  // address of the instruction after it

    // Address sums are ADDR_WIDTH wide, so they wrap from the top of the ROM to 0.
    assign pc_next = instr_two_byte ? pc + TWO : pc + ONE;

    // NOTE: every register here is assigned with <= so all of them see the
    // values from before the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_OP_ADDR;
            pc             <= RESET_VECTOR;
            rom_addr       <= RESET_VECTOR;
            instr_valid    <= 1'b0;
            instr_opcode   <= '0;
            instr_operand  <= '0;
            instr_two_byte <= 1'b0;
            instr_pc       <= '0;
        end else if (redirect_en) begin
            // Bytes already requested or latched are dropped; a handshake
            // in this same cycle has still consumed the offered instruction.
            state       <= S_OP_ADDR;
            pc          <= redirect_addr;
            rom_addr    <= redirect_addr;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_OP_ADDR: begin
                    // Operand byte is requested speculatively; for a one-byte
                    // instruction the same fetch is the next opcode.
                    rom_addr <= pc + ONE;
                    state    <= S_OP_DATA;
                end

                S_OP_DATA: begin
                    instr_opcode <= rom_data;
                    instr_pc     <= pc;
                    if (is_two_byte(rom_data)) begin
                        instr_two_byte <= 1'b1;
                        rom_addr       <= pc + TWO;
                        state          <= S_ARG_DATA;
                    end else begin
                        // rom_addr stays at pc+1, which is the next opcode.
                        instr_two_byte <= 1'b0;
                        instr_operand  <= '0;
                        instr_valid    <= 1'b1;
                        state          <= S_OUT;
                    end
                end

                S_ARG_DATA: begin
                    // rom_addr stays at pc+2, which is the next opcode.
                    instr_operand <= rom_data;
                    instr_valid   <= 1'b1;
                    state         <= S_OUT;
                end

                S_OUT: begin
                    if (instr_valid && instr_ready) begin
                        // rom_addr has held pc_next since the opcode/operand
                        // edge, so the ROM already shows the next opcode and
                        // the fetch can skip S_OP_ADDR.
                        instr_valid <= 1'b0;
                        pc          <= pc_next;
                        rom_addr    <= pc_next + ONE;
                        state       <= S_OP_DATA;
                    end
                end

                default: begin
                    state <= S_OP_ADDR;
                end
            endcase
        end
    end

endmodule

// File: doc/rom_fetch_unit.md
# rom_fetch_unit

Instruction fetch front end for the microprocessor: the initiator side of the synchronous instruction ROM interface. It drives the ROM address, captures returned bytes, and assembles one- or two-byte instructions. It presents each instruction to the execute stage with a valid/ready handshake and accepts branch/jump redirects from execute. It sits between the instruction ROM and the processor core.

## Interface
- ADDR_WIDTH, 8, ROM address width and program-counter width.
- DATA_WIDTH, 8, ROM word width; also opcode and operand width.
- RESET_VECTOR, 8'h00, first fetch address after reset.
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ROM_ADDR  out  ADDR_WIDTH  registered address to ROM.
- ROM_DATA  in  DATA_WIDTH  ROM read data. The ROM registers it on the rising edge from the ROM_ADDR seen at that edge, so latency is 1 cycle.
- INSTR_VALID  out  1  registered; instruction fields are valid.
- INSTR_READY  in  1  execute stage accepts the instruction.
- INSTR_OPCODE  out  DATA_WIDTH  opcode byte.
- INSTR_OPERAND  out  DATA_WIDTH  second byte; 8'h00 for one-byte instructions.
- INSTR_TWO_BYTE  out  1  1 when the instruction carries an operand.
- INSTR_PC  out  ADDR_WIDTH  address of the opcode byte.
- REDIRECT_EN  in  1  one-cycle request to fetch from REDIRECT_ADDR.
- REDIRECT_ADDR  in  ADDR_WIDTH  redirect target.

## Operation
- Length decode: an instruction is two bytes when opcode[3:0] ∈ {0x0, 0x1, 0x2, 0x3, 0x6, 0x7, 0x9}. Every other opcode is one byte.
- FSM states and transitions:
  - S_OP_ADDR: ROM_ADDR <= PC+1. Go to S_OP_DATA.
  - S_OP_DATA: ROM_DATA holds the opcode at PC. Latch it.
    - One-byte: PC_next = PC+1. Go to S_OUT with INSTR_VALID <= 1.
    - Two-byte: ROM_ADDR <= PC+2. Go to S_ARG_DATA.
  - S_ARG_DATA: ROM_DATA holds the byte at PC+1. Latch it as the operand; PC_next = PC+2. Go to S_OUT with INSTR_VALID <= 1.
  - S_OUT: hold all INSTR_* outputs stable until INSTR_VALID && INSTR_READY. On that handshake:
    - INSTR_VALID <= 0, PC <= PC_next, ROM_ADDR <= PC_next+1.
    - Go to S_OP_DATA. ROM_DATA already shows the opcode at PC_next, because ROM_ADDR has held PC_next for at least one edge.
- The operand byte is prefetched speculatively; a one-byte instruction reuses that fetch as the next opcode.
- All address arithmetic is modulo 2^ADDR_WIDTH.
  - Opcode at 0xFF takes its operand from 0x00.
  - PC increments from 0xFF wrap to 0x00.
- Redirect has priority over every state. On REDIRECT_EN:
  - Next edge: INSTR_VALID <= 0, PC <= REDIRECT_ADDR, ROM_ADDR <= REDIRECT_ADDR, state <= S_OP_ADDR.
  - Any in-flight bytes are discarded.
  - A handshake in the same cycle still counts as consumed; the redirect wins for next-state purposes.
- The unit never emits a partially assembled instruction.

## Timing
- Reset values (synchronous, from the edge where RESET=1):
  - state = S_OP_ADDR, PC = RESET_VECTOR, ROM_ADDR = RESET_VECTOR.
  - INSTR_VALID = 0, INSTR_OPCODE = 0, INSTR_OPERAND = 0, INSTR_TWO_BYTE = 0, INSTR_PC = 0.
- Reset asserted mid-instruction (any state, including S_OUT with INSTR_VALID=1): all of the above at the next edge; RESET has priority over REDIRECT_EN.
- Latency from the first cycle after reset release (cycle 0) or from a redirect edge:
  - one-byte instruction: INSTR_VALID high in cycle 2.
  - two-byte instruction: INSTR_VALID high in cycle 3.
- Sustained throughput with INSTR_READY tied high: one instruction per 2 cycles (one-byte) or per 3 cycles (two-byte).
- INSTR_VALID falls in the cycle after a handshake; there are no back-to-back valid cycles.
- INSTR_READY may be high before INSTR_VALID; this has no effect.

## Structure
- Shared package rom_fetch_pkg holds:
  - state encoding (S_OP_ADDR, S_OP_DATA, S_ARG_DATA, S_OUT);
  - the two-byte opcode nibble set;
  - function is_two_byte(opcode).
- The processor decoder imports the same package so both agree on instruction length.
- Single module, no sub-modules. The bench reuses the existing ROM model as the responder.

## Test plan
- ROM[0x00]=0x04, ROM[0x01]=0x05, READY=1 -> INSTR_VALID in cycle 2 with OPCODE 0x04, PC 0x00, TWO_BYTE 0; next instruction OPCODE 0x05, PC 0x01 in cycle 4.
- ROM[0x00]=0x07, ROM[0x01]=0x10 -> OPCODE 0x07, OPERAND 0x10, TWO_BYTE 1 in cycle 3; next fetch at PC 0x02.
- Hold READY=0 for 5 cycles while valid -> all INSTR_* outputs stable; after READY=1 the next instruction arrives 2 cycles later.
- REDIRECT_EN with ADDR 0x40 while in S_ARG_DATA -> VALID low, ROM_ADDR 0x40 next edge, instruction from 0x40 valid 2 cycles after that (one-byte opcode).
- Two-byte opcode at 0xFF with ROM[0x00]=0xAB -> OPERAND 0xAB, next PC 0x01.
- RESET pulse during S_OUT -> VALID 0 and ROM_ADDR RESET_VECTOR next edge; fetch restarts cleanly.
